// File: rtl/dpram_clr.sv
// dpram_clr -- single-clock true dual-port RAM with per-byte write enables,
// selectable same-port read-during-write, per-lane write-collision resolution
// and an optional clear engine.
//
// Optional feature macro: DPRAM_CLEAR_EN
//   defined   : an IDLE/CLEAR sweep writes init_value to every location after
//               reset and on each clear request; busy flags the sweep.
//   undefined : no sweep, busy tied low, clear ignored; reset only zeroes q_a/q_b.
//
// Parameters:
//   widthad_a  address width (depth = 2**widthad_a)
//   width_a    data width, multiple of bytew
//   bytew      byte-lane width
//   rdw_mode   same-port read-during-write: 0 = old data, 1 = merged new data
//   init_value word written by the clear sweep
//
// Ports:
//   clock                 rising-edge clock
//   reset                 asynchronous, active-high
//   clear                 one-cycle request to re-run the sweep (ignored while busy)
//   busy                  sweep in progress; port accesses dropped, q held at 0
//   address_a/b           port address
//   data_a/b              port write data
//   wren_a/b              port write enable
//   byteena_a/b           lane enables, bit i covers data[i*bytew +: bytew]
//   q_a/b                 registered read data, 1-cycle latency
module dpram_clr #(
    parameter int                 widthad_a  = 8,
    parameter int                 width_a    = 8,
    parameter int                 bytew      = 8,
    parameter int                 rdw_mode   = 0,
    parameter logic [width_a-1:0] init_value = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    output logic                       busy,
    input  logic [widthad_a-1:0]       address_a,
    input  logic [width_a-1:0]         data_a,
    input  logic                       wren_a,
    input  logic [width_a/bytew-1:0]   byteena_a,
    output logic [width_a-1:0]         q_a,
    input  logic [widthad_a-1:0]       address_b,
    input  logic [width_a-1:0]         data_b,
    input  logic                       wren_b,
    input  logic [width_a/bytew-1:0]   byteena_b,
    output logic [width_a-1:0]         q_b
);

    localparam int lanes = width_a / bytew;
    localparam int depth = 1 << widthad_a;

    logic [width_a-1:0]   mem [depth];
    logic [width_a-1:0]   old_a;
    logic [width_a-1:0]   old_b;
    logic [width_a-1:0]   merged_a;
    logic [width_a-1:0]   merged_b;
    logic [width_a-1:0]   combined;
    logic                 collide;
    logic                 clr_we;
    logic [widthad_a-1:0] clr_addr;

`ifdef DPRAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [widthad_a-1:0] cnt;
    logic [widthad_a-1:0] cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A clear request arriving mid-sweep is simply not looked at.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (&cnt) state_nxt = IDLE;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // The single-bit state register is busy itself, so busy has no input path.
    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;
`else
    logic unused_clear;

    assign unused_clear = clear;
    assign busy         = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
`endif

    assign old_a   = mem[address_a];
    assign old_b   = mem[address_b];
    assign collide = wren_a && wren_b && (address_a == address_b);

    // merged_x: the word port x would leave behind on its own.
    // combined: both ports on one address, port A owning every lane it enables.
    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < lanes; i++) begin
            if (byteena_a[i]) merged_a[i*bytew +: bytew] = data_a[i*bytew +: bytew];
            if (byteena_b[i]) merged_b[i*bytew +: bytew] = data_b[i*bytew +: bytew];
        end
        combined = merged_b;
        for (int i = 0; i < lanes; i++) begin
            if (byteena_a[i]) combined[i*bytew +: bytew] = data_a[i*bytew +: bytew];
        end
    end

    // The sweep owns the array while it runs; port writes are dropped then.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= init_value;
        end else if (collide) begin
            mem[address_a] <= combined;
        end else begin
            if (wren_a) mem[address_a] <= merged_a;
            if (wren_b) mem[address_b] <= merged_b;
        end
    end

    // Cross-port reads always see the pre-write word; only a port's own
    // write can show through, and only in write-first mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else if (busy) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= (rdw_mode == 1 && wren_a) ? merged_a : old_a;
            q_b <= (rdw_mode == 1 && wren_b) ? merged_b : old_b;
        end
    end

endmodule

// File: tb/tb_dpram_clr.sv
// Bench for dpram_clr: two instances (read-first and write-first) share all
// inputs and are compared against an array-based reference model.
module tb_dpram_clr;

    localparam logic [15:0] INIT = 16'hA5A5;
`ifdef DPRAM_CLEAR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  address_a = '0, address_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        wren_a = 1'b0, wren_b = 1'b0;
    logic [1:0]  byteena_a = '0, byteena_b = '0;
    logic        busy0, busy1;
    logic [15:0] q_a0, q_b0, q_a1, q_b1;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dpram_clr #(.widthad_a(4), .width_a(16), .bytew(8), .rdw_mode(0), .init_value(INIT)) dut0 (
        .clock(clock), .reset(reset), .clear(clear), .busy(busy0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a), .q_a(q_a0),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b), .q_b(q_b0));

    dpram_clr #(.widthad_a(4), .width_a(16), .bytew(8), .rdw_mode(1), .init_value(INIT)) dut1 (
        .clock(clock), .reset(reset), .clear(clear), .busy(busy1),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a), .q_a(q_a1),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b), .q_b(q_b1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: memory contents, which words are known, sweep progress.
    logic [15:0] mm [16];
    bit          mv [16];
    bit          m_busy;
    int          m_cnt;
    logic [15:0] e_qa0, e_qb0, e_qa1, e_qb1;
    bit          e_va, e_vb;

    function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] d,
                                               input logic [1:0] be, input logic we);
        logic [15:0] r;
        r = old;
        if (we)
            for (int i = 0; i < 2; i++)
                if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = HAS_CLR;
        m_cnt  = 0;
        e_qa0 = '0; e_qb0 = '0; e_qa1 = '0; e_qb1 = '0;
        e_va = 1'b1; e_vb = 1'b1;
    endtask

    task automatic model_step();
        if (m_busy) begin
            e_qa0 = '0; e_qb0 = '0; e_qa1 = '0; e_qb1 = '0;
            e_va = 1'b1; e_vb = 1'b1;
            mm[m_cnt] = INIT;
            mv[m_cnt] = 1'b1;
            if (m_cnt == 15) m_busy = 1'b0;
            m_cnt++;
        end else begin
            e_va  = mv[address_a];
            e_vb  = mv[address_b];
            e_qa0 = mm[address_a];
            e_qb0 = mm[address_b];
            e_qa1 = lane_merge(mm[address_a], data_a, byteena_a, wren_a);
            e_qb1 = lane_merge(mm[address_b], data_b, byteena_b, wren_b);
            // B first, then A on top: A owns any lane both ports enable.
            if (wren_b) begin
                mm[address_b] = lane_merge(mm[address_b], data_b, byteena_b, 1'b1);
                if (byteena_b == 2'b11) mv[address_b] = 1'b1;
            end
            if (wren_a) begin
                mm[address_a] = lane_merge(mm[address_a], data_a, byteena_a, 1'b1);
                if (byteena_a == 2'b11) mv[address_a] = 1'b1;
            end
            if (HAS_CLR && clear) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic step();
        if (reset) model_reset();
        else       model_step();
        @(posedge clock);
        #1;
        check("busy0", {31'b0, busy0}, {31'b0, m_busy});
        check("busy1", {31'b0, busy1}, {31'b0, m_busy});
        if (e_va) begin
            check("q_a_rf", {16'b0, q_a0}, {16'b0, e_qa0});
            check("q_a_wf", {16'b0, q_a1}, {16'b0, e_qa1});
        end
        if (e_vb) begin
            check("q_b_rf", {16'b0, q_b0}, {16'b0, e_qb0});
            check("q_b_wf", {16'b0, q_b1}, {16'b0, e_qb1});
        end
    endtask

    task automatic drive(input logic [3:0] aa, input logic [15:0] da, input logic wa, input logic [1:0] ba,
                         input logic [3:0] ab, input logic [15:0] db, input logic wb, input logic [1:0] bb);
        address_a = aa; data_a = da; wren_a = wa; byteena_a = ba;
        address_b = ab; data_b = db; wren_b = wb; byteena_b = bb;
        step();
    endtask

    task automatic idle();
        drive(4'($urandom_range(0, 15)), 16'h0, 1'b0, 2'b00, 4'($urandom_range(0, 15)), 16'h0, 1'b0, 2'b00);
    endtask

    // Counts edges with busy high, bounded so a stuck busy cannot hang the run.
    task automatic count_sweep(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            idle();
            n++;
        end
    endtask

    task automatic read_all_init();
        for (int a = 0; a < 16; a++) begin
            drive(4'(a), 16'h0, 1'b0, 2'b00, 4'(15 - a), 16'h0, 1'b0, 2'b00);
            check("init_a", {16'b0, q_a0}, {16'b0, INIT});
            check("init_b", {16'b0, q_b1}, {16'b0, INIT});
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mm[i] = '0;
            mv[i] = 1'b0;
        end
        model_reset();

        // Power-up reset
        #2 reset = 1'b1;
        #1;
        check("rst_q_a", {16'b0, q_a0}, 32'h0);
        check("rst_q_b", {16'b0, q_b1}, 32'h0);
        check("rst_busy", {31'b0, busy0}, {31'b0, HAS_CLR});
        step();
        step();
        reset = 1'b0;

`ifdef DPRAM_CLEAR_EN
        count_sweep(n);
        check("sweep_len", n, 16);
        read_all_init();
`else
        drive(4'd9, 16'hC3C3, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd9, 16'h0, 1'b0, 2'b00, 4'd9, 16'h0, 1'b0, 2'b00);
        check("first_wr", {16'b0, q_a0}, 32'h0000_C3C3);
        check("busy_off", {31'b0, busy0}, 32'h0);
        for (int a = 0; a < 8; a++)
            drive(4'(a), 16'($urandom), 1'b1, 2'b11, 4'(15 - a), 16'($urandom), 1'b1, 2'b11);
`endif

        // Byte lanes
        drive(4'd3, 16'h1234, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd3, 16'hABCD, 1'b1, 2'b10, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd3, 16'h0, 1'b0, 2'b00, 4'd3, 16'h0, 1'b0, 2'b00);
        check("bytelane", {16'b0, q_a0}, 32'h0000_AB34);
        // byteena=0 is a no-op
        drive(4'd3, 16'hFFFF, 1'b1, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd3, 16'h0, 1'b0, 2'b00, 4'd3, 16'h0, 1'b0, 2'b00);
        check("be_zero", {16'b0, q_b0}, 32'h0000_AB34);

        // Same-port read-during-write and cross-port read
        drive(4'd5, 16'h1111, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd5, 16'h2222, 1'b1, 2'b11, 4'd5, 16'h0, 1'b0, 2'b00);
        check("rdw_rf", {16'b0, q_a0}, 32'h0000_1111);
        check("rdw_wf", {16'b0, q_a1}, 32'h0000_2222);
        check("xport_rf", {16'b0, q_b0}, 32'h0000_1111);
        check("xport_wf", {16'b0, q_b1}, 32'h0000_1111);

        // Write collision
        drive(4'd7, 16'hAAAA, 1'b1, 2'b01, 4'd7, 16'hBBBB, 1'b1, 2'b11);
        drive(4'd7, 16'h0, 1'b0, 2'b00, 4'd7, 16'h0, 1'b0, 2'b00);
        check("collide", {16'b0, q_a0}, 32'h0000_BBAA);

        // Randomized traffic, occasional clear requests
        for (int k = 0; k < 400; k++) begin
            logic [3:0] aa, ab;
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 39) == 0);
            drive(aa, 16'($urandom), 1'($urandom), 2'($urandom), ab, 16'($urandom), 1'($urandom), 2'($urandom));
        end
        clear = 1'b0;

        // Asynchronous reset with non-zero q
`ifdef DPRAM_CLEAR_EN
        count_sweep(n);
`endif
        drive(4'd2, 16'h1357, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd2, 16'h0, 1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 2'b00);
        reset = 1'b1;
        #1;
        check("arst_q_a", {16'b0, q_a0}, 32'h0);
        check("arst_q_b", {16'b0, q_b1}, 32'h0);
        check("arst_busy", {31'b0, busy0}, {31'b0, HAS_CLR});
        step();
        reset = 1'b0;

`ifdef DPRAM_CLEAR_EN
        count_sweep(n);
        check("sweep_len2", n, 16);
        // clear mid-sweep ignored, then reset at counter=7
        clear = 1'b1;
        idle();
        clear = 1'b0;
        idle(); idle(); idle();
        clear = 1'b1;
        idle();
        clear = 1'b0;
        idle(); idle(); idle();
        check("mid_busy", {31'b0, busy0}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy1}, 32'h1);
        step();
        step();
        reset = 1'b0;
        count_sweep(n);
        check("sweep_restart", n, 16);
        read_all_init();
`else
        drive(4'd11, 16'h6E5D, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 2'b00);
        drive(4'd11, 16'h0, 1'b0, 2'b00, 4'd11, 16'h0, 1'b0, 2'b00);
        check("first_wr2", {16'b0, q_b1}, 32'h0000_6E5D);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check("clr_ignored", {31'b0, busy0}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
